// File: rtl/lin_slave_sub_rx.sv
// ----------------------------------------------------------------------------
// lin_slave_sub_rx
//   Subscriber-side response receiver of a LIN slave node. Once a header has
//   been accepted (pid_valid), it collects DATA_BYTES framed data symbols and
//   one checksum symbol from the bus deserialiser, verifies the LIN checksum
//   (classic or enhanced), and writes the payload into slave memory as 32-bit
//   words. Per-frame error flags are kept sticky on status_error until the
//   next frame starts.
//
// Ports
//   clk              system clock
//   reset            asynchronous active-low reset
//   en_slv_operation block enable; low forces IDLE, no writes
//   pid_valid        1-cycle pulse: header checked, this node subscribes
//   pid_byte         protected identifier {P1,P0,ID[5:0]}, sampled on pid_valid
//   start_addr       memory word address of the first payload word
//   rx_valid         1-cycle strobe: rx_symbol holds a new bus symbol
//   rx_symbol        framed symbol {stop(1), data[7:0], start(0)}
//   SWR_en           memory write strobe, one cycle per word
//   SWR_ADDR         memory write word address (held when SWR_en=0)
//   SWR_data         memory write data, byte n at [8n+7:8n] (held when SWR_en=0)
//   resp_done        1-cycle pulse: frame accepted and fully written
//   status_error     [0] checksum, [1] framing, [2] timeout, [3] restart
// ----------------------------------------------------------------------------
module lin_slave_sub_rx #(
    parameter int unsigned DATA_BYTES        = 8,
    parameter int unsigned INACTIVE          = 20,
    parameter bit          CHECKSUM_ENHANCED = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en_slv_operation,
    input  logic        pid_valid,
    input  logic [7:0]  pid_byte,
    input  logic [31:0] start_addr,
    input  logic        rx_valid,
    input  logic [9:0]  rx_symbol,
    output logic        SWR_en,
    output logic [31:0] SWR_ADDR,
    output logic [31:0] SWR_data,
    output logic        resp_done,
    output logic [7:0]  status_error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DATA,
        S_CHK,
        S_WR0,
        S_WR1,
        S_DONE
    } state_t;

    localparam logic [2:0]        LAST_IDX = 3'(DATA_BYTES - 1);
    localparam int unsigned       TW       = $clog2(INACTIVE + 1);
    localparam logic [TW-1:0]     TMO_LAST = TW'(INACTIVE - 1);

    state_t          state_q, state_d;
    logic [2:0]      cnt_q, cnt_d;
    logic [7:0]      sum_q, sum_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [63:0]     buf_q, buf_d;
    logic [31:0]     addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [3:0]      err_q, err_d;

    logic [7:0]      byte_in;
    logic [7:0]      sum_in;
    logic            frame_ok;
    logic            timed_out;

    // 8-bit add with end-around carry, as used by the LIN checksum.
    function automatic logic [7:0] add_wrap(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[7:0] + {7'b0, s[8]};
    endfunction

    // Diagnostic frames 0x3C/0x3D always use the classic checksum.
    function automatic logic [7:0] seed_sum(input logic [7:0] pid);
        if (CHECKSUM_ENHANCED && (pid[5:0] != 6'h3C) && (pid[5:0] != 6'h3D)) begin
            return add_wrap(8'h00, pid);
        end
        return 8'h00;
    endfunction

    assign byte_in   = rx_symbol[8:1];
    assign frame_ok  = (rx_symbol[0] == 1'b0) && (rx_symbol[9] == 1'b1);
    assign sum_in    = add_wrap(sum_q, byte_in);
    assign timed_out = (timer_q == TMO_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            sum_q   <= '0;
            timer_q <= '0;
            buf_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            timer_q <= timer_d;
            buf_q   <= buf_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
        end
    end

    // Write address/data are loaded on the transition into WR0/WR1, so the
    // registered values line up with SWR_en decoded from the state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        timer_d = timer_q;
        buf_d   = buf_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        err_d   = err_q;

        if (!en_slv_operation) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (pid_valid) begin
                        state_d = S_DATA;
                        cnt_d   = '0;
                        timer_d = '0;
                        err_d   = '0;
                        sum_d   = seed_sum(pid_byte);
                    end
                end

                S_DATA, S_CHK: begin
                    if (pid_valid) begin
                        // New header mid-response: flag it and start over.
                        state_d  = S_DATA;
                        cnt_d    = '0;
                        timer_d  = '0;
                        err_d[3] = 1'b1;
                        sum_d    = seed_sum(pid_byte);
                    end else if (rx_valid) begin
                        timer_d = '0;
                        if (!frame_ok) begin
                            err_d[1] = 1'b1;
                            state_d  = S_IDLE;
                        end else if (state_q == S_DATA) begin
                            buf_d[{cnt_q, 3'b000} +: 8] = byte_in;
                            sum_d = sum_in;
                            cnt_d = cnt_q + 3'd1;
                            if (cnt_q == LAST_IDX) begin
                                state_d = S_CHK;
                            end
                        end else if (sum_in == 8'hFF) begin
                            state_d = S_WR0;
                            addr_d  = start_addr;
                            wdata_d = buf_q[31:0];
                        end else begin
                            err_d[0] = 1'b1;
                            state_d  = S_IDLE;
                        end
                    end else if (timed_out) begin
                        err_d[2] = 1'b1;
                        state_d  = S_IDLE;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end

                S_WR0: begin
                    if (DATA_BYTES == 8) begin
                        state_d = S_WR1;
                        addr_d  = addr_q + 32'd1;
                        wdata_d = buf_q[63:32];
                    end else begin
                        state_d = S_DONE;
                    end
                end

                S_WR1:   state_d = S_DONE;
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign SWR_en       = (state_q == S_WR0) || (state_q == S_WR1);
    assign SWR_ADDR     = addr_q;
    assign SWR_data     = wdata_q;
    assign resp_done    = (state_q == S_DONE);
    assign status_error = {4'b0000, err_q};

endmodule

// File: tb/tb_lin_slave_sub_rx.sv
// ----------------------------------------------------------------------------
// tb_lin_slave_sub_rx
//   Drives two receivers (enhanced and classic checksum) with the same bus
//   traffic and checks writes, completion pulses and error flags against a
//   reference computed from the LIN checksum rules with plain arithmetic.
// ----------------------------------------------------------------------------
module tb_lin_slave_sub_rx;

    logic        clk = 1'b0;
    logic        reset;
    logic        en_slv_operation;
    logic        pid_valid;
    logic [7:0]  pid_byte;
    logic [31:0] start_addr;
    logic        rx_valid;
    logic [9:0]  rx_symbol;

    logic        swr_en    [2];
    logic [31:0] swr_addr  [2];
    logic [31:0] swr_data  [2];
    logic        resp_done [2];
    logic [7:0]  status    [2];

    int n_cmp = 0;
    int n_mis = 0;

    logic [63:0] wq0[$];
    logic [63:0] wq1[$];
    int dn0 = 0;
    int dn1 = 0;

    lin_slave_sub_rx #(.DATA_BYTES(8), .INACTIVE(20), .CHECKSUM_ENHANCED(1'b1)) u_enh (
        .clk(clk), .reset(reset), .en_slv_operation(en_slv_operation),
        .pid_valid(pid_valid), .pid_byte(pid_byte), .start_addr(start_addr),
        .rx_valid(rx_valid), .rx_symbol(rx_symbol),
        .SWR_en(swr_en[0]), .SWR_ADDR(swr_addr[0]), .SWR_data(swr_data[0]),
        .resp_done(resp_done[0]), .status_error(status[0])
    );

    lin_slave_sub_rx #(.DATA_BYTES(8), .INACTIVE(20), .CHECKSUM_ENHANCED(1'b0)) u_cls (
        .clk(clk), .reset(reset), .en_slv_operation(en_slv_operation),
        .pid_valid(pid_valid), .pid_byte(pid_byte), .start_addr(start_addr),
        .rx_valid(rx_valid), .rx_symbol(rx_symbol),
        .SWR_en(swr_en[1]), .SWR_ADDR(swr_addr[1]), .SWR_data(swr_data[1]),
        .resp_done(resp_done[1]), .status_error(status[1])
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (swr_en[0])    wq0.push_back({swr_addr[0], swr_data[0]});
        if (swr_en[1])    wq1.push_back({swr_addr[1], swr_data[1]});
        if (resp_done[0]) dn0++;
        if (resp_done[1]) dn1++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Ones'-complement style total: sum everything, then fold carries back.
    function automatic int fold(input int s);
        int r;
        r = s;
        while (r > 255) r = (r & 255) + (r >> 8);
        return r;
    endfunction

    function automatic int raw_sum(input bit enh, input logic [7:0] pid, input logic [63:0] data);
        int s;
        s = 0;
        if (enh && pid[5:0] != 6'h3C && pid[5:0] != 6'h3D) s = int'(pid);
        for (int k = 0; k < 8; k++) s += int'(data[8*k +: 8]);
        return s;
    endfunction

    function automatic bit model_accept(input bit enh, input logic [7:0] pid,
                                        input logic [63:0] data, input logic [7:0] cks);
        return fold(raw_sum(enh, pid, data) + int'(cks)) == 255;
    endfunction

    function automatic logic [7:0] good_cks(input bit enh, input logic [7:0] pid, input logic [63:0] data);
        logic [7:0] f;
        f = 8'(fold(raw_sum(enh, pid, data)));
        return ~f;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_pid(input logic [7:0] p);
        pid_byte  = p;
        pid_valid = 1'b1;
        tick();
        pid_valid = 1'b0;
        pid_byte  = 8'($urandom);
    endtask

    task automatic send_sym(input logic [9:0] s, input int gap);
        repeat (gap) tick();
        rx_symbol = s;
        rx_valid  = 1'b1;
        tick();
        rx_valid  = 1'b0;
        rx_symbol = 10'($urandom);
    endtask

    task automatic check_zero_outputs(input string tag);
        for (int d = 0; d < 2; d++) begin
            check({tag, "_en"},   64'(swr_en[d]),    64'd0);
            check({tag, "_addr"}, 64'(swr_addr[d]),  64'd0);
            check({tag, "_data"}, 64'(swr_data[d]),  64'd0);
            check({tag, "_done"}, 64'(resp_done[d]), 64'd0);
            check({tag, "_stat"}, 64'(status[d]),    64'd0);
        end
    endtask

    // kind: 0 normal, 1 framing error at symbol pos, 2 silence before symbol pos,
    //       3 new header before symbol pos, 4 enable drop before symbol pos,
    //       5 reset during symbol pos
    task automatic run_frame(input logic [7:0] pid, input logic [31:0] addr,
                             input logic [63:0] data, input logic [7:0] cks,
                             input int kind, input int pos, input bit stop0);
        bit          acc0, acc1, aborted, ea0, ea1, restarted, stop;
        logic [7:0]  es0, es1, b;
        logic [9:0]  sym;
        logic [31:0] addr1;
        int          i, gap;

        acc0    = model_accept(1'b1, pid, data, cks);
        acc1    = model_accept(1'b0, pid, data, cks);
        aborted = (kind == 1) || (kind == 2) || (kind == 4) || (kind == 5);
        ea0     = acc0 && !aborted;
        ea1     = acc1 && !aborted;
        case (kind)
            0:       begin es0 = acc0 ? 8'h00 : 8'h01; es1 = acc1 ? 8'h00 : 8'h01; end
            1:       begin es0 = 8'h02; es1 = 8'h02; end
            2:       begin es0 = 8'h04; es1 = 8'h04; end
            3:       begin es0 = acc0 ? 8'h08 : 8'h09; es1 = acc1 ? 8'h08 : 8'h09; end
            default: begin es0 = 8'h00; es1 = 8'h00; end
        endcase
        addr1 = addr + 32'd1;

        wq0.delete();
        wq1.delete();
        dn0 = 0;
        dn1 = 0;
        start_addr = addr;
        send_pid(pid);

        i = 0;
        restarted = 1'b0;
        stop = 1'b0;
        while (i < 9 && !stop) begin
            b   = (i < 8) ? data[8*i +: 8] : cks;
            sym = {1'b1, b, 1'b0};
            gap = ($urandom_range(0, 9) == 0) ? 19 : int'($urandom_range(0, 2));
            if (kind == 3 && i == pos && !restarted) begin
                send_pid(pid);
                restarted = 1'b1;
                i = 0;
            end else if (kind == 2 && i == pos) begin
                repeat (19) tick();
                check("tmo_early_enh", 64'(status[0]), 64'h00);
                check("tmo_early_cls", 64'(status[1]), 64'h00);
                tick();
                check("tmo_enh", 64'(status[0]), 64'h04);
                check("tmo_cls", 64'(status[1]), 64'h04);
                stop = 1'b1;
            end else begin
                if (kind == 1 && i == pos) begin
                    if (stop0 || $urandom_range(0, 1) == 0) sym[9] = 1'b0;
                    else sym[0] = 1'b1;
                end
                if (kind == 4 && i == pos) begin
                    en_slv_operation = 1'b0;
                    tick();
                    en_slv_operation = 1'b1;
                    check("endrop_enh", 64'(status[0]), 64'h00);
                    check("endrop_cls", 64'(status[1]), 64'h00);
                end
                if (kind == 5 && i == pos) begin
                    repeat (gap) tick();
                    rx_symbol = sym;
                    rx_valid  = 1'b1;
                    reset     = 1'b0;
                    #1;
                    check_zero_outputs("midreset");
                    tick();
                    rx_valid = 1'b0;
                    reset    = 1'b1;
                end else begin
                    send_sym(sym, gap);
                end
                if (kind == 1 && i == pos) begin
                    check("framing_enh", 64'(status[0]), 64'h02);
                    check("framing_cls", 64'(status[1]), 64'h02);
                    stop = 1'b1;
                end else if (i == 8) begin
                    check("lat_wr0_enh", 64'(swr_en[0]), 64'(ea0));
                    check("lat_wr0_cls", 64'(swr_en[1]), 64'(ea1));
                    tick();
                    check("lat_wr1_enh", 64'(swr_en[0]), 64'(ea0));
                    check("lat_wr1_cls", 64'(swr_en[1]), 64'(ea1));
                    check("early_done_enh", 64'(resp_done[0]), 64'd0);
                    tick();
                    check("lat_done_enh", 64'(resp_done[0]), 64'(ea0));
                    check("lat_done_cls", 64'(resp_done[1]), 64'(ea1));
                    check("wr_end_enh", 64'(swr_en[0]), 64'd0);
                end
                i++;
            end
        end

        repeat (3) tick();
        check("nwr_enh", 64'(wq0.size()), ea0 ? 64'd2 : 64'd0);
        check("nwr_cls", 64'(wq1.size()), ea1 ? 64'd2 : 64'd0);
        if (ea0 && wq0.size() == 2) begin
            check("w0_enh", wq0[0], {addr,  data[31:0]});
            check("w1_enh", wq0[1], {addr1, data[63:32]});
        end
        if (ea1 && wq1.size() == 2) begin
            check("w0_cls", wq1[0], {addr,  data[31:0]});
            check("w1_cls", wq1[1], {addr1, data[63:32]});
        end
        check("ndone_enh", 64'(dn0), 64'(ea0));
        check("ndone_cls", 64'(dn1), 64'(ea1));
        check("status_enh", 64'(status[0]), 64'(es0));
        check("status_cls", 64'(status[1]), 64'(es1));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish within time limit");
        $fatal(1);
    end

    initial begin
        logic [63:0] d;
        logic [7:0]  pid, cks;
        int          r, kind;

        reset            = 1'b0;
        en_slv_operation = 1'b1;
        pid_valid        = 1'b0;
        pid_byte         = 8'h00;
        start_addr       = 32'h0;
        rx_valid         = 1'b0;
        rx_symbol        = 10'h0;
        repeat (2) tick();
        check_zero_outputs("reset");
        reset = 1'b1;
        tick();

        d = 64'h0807060504030201;
        run_frame(8'h25, 32'h100, d, 8'hB6, 0, 0, 1'b0);
        run_frame(8'h25, 32'h100, d, 8'hDB, 0, 0, 1'b0);
        run_frame(8'h3C, 32'h200, d, 8'hDB, 0, 0, 1'b0);
        run_frame(8'h25, 32'h100, d, 8'hB6, 1, 2, 1'b1);
        run_frame(8'h25, 32'h100, d, 8'hB6, 2, 5, 1'b0);
        run_frame(8'h25, 32'h104, d, 8'hB6, 0, 0, 1'b0);
        run_frame(8'h25, 32'h100, d, 8'hB6, 3, 3, 1'b0);
        run_frame(8'h25, 32'h100, d, 8'hB6, 5, 5, 1'b0);
        run_frame(8'h25, 32'h100, d, 8'hB6, 4, 4, 1'b0);

        for (int n = 0; n < 60; n++) begin
            pid = 8'($urandom);
            if ($urandom_range(0, 5) == 0) pid[5:0] = 6'($urandom_range(60, 61));
            d = {32'($urandom), 32'($urandom)};
            r = int'($urandom_range(0, 3));
            if (r <= 1)      cks = good_cks(1'b1, pid, d);
            else if (r == 2) cks = good_cks(1'b0, pid, d);
            else             cks = 8'($urandom);
            r = int'($urandom_range(0, 9));
            kind = (r <= 4) ? 0 : r - 4;
            run_frame(pid, 32'($urandom), d, cks, kind, int'($urandom_range(0, 8)), 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
